// File: rtl/lsq_v2.sv
// lsq_v2: in-order load/store queue between the issuer, two CDBs and a byte-strobed word memory/IO port.
// Latency: an entry can request memory two cycles after its base is ready. A load result pulses the cycle after mem_ready.
// Backpressure: full when count >= DEPTH-FULL_SLACK. A memory request is held stable until mem_ready.
// Ports: clk/rst/rdy control; issue_* writes one entry at tail; cdb0/cdb1 broadcast operand values;
//        rob_head_id gates IO loads; commit_store marks one more store safe to write; flush drops speculative entries;
//        result_* is the load completion pulse; full/empty report occupancy; mem_* is the single-outstanding memory port.
module lsq_v2 #(
    parameter int          DEPTH      = 16,
    parameter int          ROB_ID_W   = 4,
    parameter logic [31:0] IO_BASE    = 32'h0003_0000,
    parameter int          FULL_SLACK = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                rdy,
    input  logic                issue_valid,
    input  logic [3:0]          issue_op,
    input  logic [ROB_ID_W-1:0] issue_dest,
    input  logic [ROB_ID_W-1:0] issue_qj,
    input  logic [ROB_ID_W-1:0] issue_qk,
    input  logic [31:0]         issue_vj,
    input  logic [31:0]         issue_vk,
    input  logic [31:0]         issue_imm,
    input  logic [ROB_ID_W-1:0] cdb0_dest,
    input  logic [31:0]         cdb0_value,
    input  logic [ROB_ID_W-1:0] cdb1_dest,
    input  logic [31:0]         cdb1_value,
    input  logic [ROB_ID_W-1:0] rob_head_id,
    input  logic                commit_store,
    input  logic                flush,
    output logic [ROB_ID_W-1:0] result_dest,
    output logic [31:0]         result_value,
    output logic                full,
    output logic                empty,
    output logic                mem_valid,
    output logic                mem_we,
    output logic                mem_io,
    output logic [31:0]         mem_addr,
    output logic [31:0]         mem_wdata,
    output logic [3:0]          mem_wstrb,
    input  logic                mem_ready,
    input  logic [31:0]         mem_rdata
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {IDLE, REQ, DRAIN} state_t;

    state_t state, state_nxt;

    // Entry storage
    logic [DEPTH-1:0]    e_valid;
    logic [DEPTH-1:0]    e_store;
    logic [DEPTH-1:0]    e_addr_ok;
    logic [2:0]          e_funct3 [DEPTH];
    logic [ROB_ID_W-1:0] e_dest   [DEPTH];
    logic [ROB_ID_W-1:0] e_qj     [DEPTH];
    logic [ROB_ID_W-1:0] e_qk     [DEPTH];
    logic [31:0]         e_vj     [DEPTH];
    logic [31:0]         e_vk     [DEPTH];
    logic [31:0]         e_imm    [DEPTH];
    logic [31:0]         e_addr   [DEPTH];

    logic [PTR_W-1:0] head, tail, head_nxt, tail_nxt;
    logic [CNT_W-1:0] count, committed_cnt, count_nxt, cc_after, cc_nxt;

    // Attributes of the request in flight, needed to format the load result
    logic                req_store;
    logic [2:0]          req_funct3;
    logic [ROB_ID_W-1:0] req_dest;
    logic [1:0]          req_off;

    logic                start, retire, pulse, store_retire, issue_accept;
    logic [DEPTH-1:0]    keep;
    logic [ROB_ID_W-1:0] qj_cap, qk_cap;
    logic [31:0]         vj_cap, vk_cap;
    logic [31:0]         ld_shift, ld_ext;
    logic [3:0]          strb_c;
    logic [31:0]         wdata_c;

    // Head entry view
    logic       h_store, h_io;
    logic [1:0] h_off;
    assign h_store = e_store[head];
    assign h_io    = (e_addr[head] >= IO_BASE);
    assign h_off   = e_addr[head][1:0];

    assign full  = (count >= CNT_W'(DEPTH - FULL_SLACK));
    assign empty = (count == '0);

    assign issue_accept = issue_valid && !flush && (count != CNT_W'(DEPTH));

    // Operand capture at issue: a broadcast in the issue cycle would otherwise be missed
    always_comb begin
        qj_cap = issue_qj;
        vj_cap = issue_vj;
        qk_cap = issue_qk;
        vk_cap = issue_vk;
        if (issue_qj != '0) begin
            if (issue_qj == cdb0_dest) begin
                qj_cap = '0;
                vj_cap = cdb0_value;
            end else if (issue_qj == cdb1_dest) begin
                qj_cap = '0;
                vj_cap = cdb1_value;
            end
        end
        if (issue_qk != '0) begin
            if (issue_qk == cdb0_dest) begin
                qk_cap = '0;
                vk_cap = cdb0_value;
            end else if (issue_qk == cdb1_dest) begin
                qk_cap = '0;
                vk_cap = cdb1_value;
            end
        end
    end

    // Control FSM: next state and per-cycle control strobes
    always_comb begin
        state_nxt = state;
        start     = 1'b0;
        retire    = 1'b0;
        pulse     = 1'b0;
        case (state)
            IDLE: begin
                // Nothing starts in a flush cycle: the head is either speculative or
                // a committed store that can start next cycle just as well.
                if (!flush && count != '0 && e_valid[head] && e_addr_ok[head]) begin
                    if (h_store)
                        start = (e_qk[head] == '0) && (committed_cnt != '0 || commit_store);
                    else if (h_io)
                        start = (e_dest[head] == rob_head_id);
                    else
                        start = 1'b1;
                end
                if (start)
                    state_nxt = REQ;
            end
            REQ: begin
                if (mem_ready) begin
                    retire    = 1'b1;
                    pulse     = !req_store && !flush;
                    state_nxt = IDLE;
                end else if (flush && !req_store) begin
                    // Drop the speculative load from the queue now; the port still
                    // owes the memory a handshake, which DRAIN absorbs.
                    retire    = 1'b1;
                    state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                if (mem_ready)
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign store_retire = retire && req_store;

    // Pointer and counter next values
    always_comb begin
        head_nxt  = head + PTR_W'(retire);
        cc_after  = committed_cnt - CNT_W'(store_retire);
        cc_nxt    = flush ? cc_after : cc_after + CNT_W'(commit_store);
        count_nxt = flush ? cc_nxt : count + CNT_W'(issue_accept) - CNT_W'(retire);
        tail_nxt  = flush ? head_nxt + PTR_W'(cc_nxt) : tail + PTR_W'(issue_accept);
    end

    // On flush only the committed stores, which are always the oldest entries, survive
    always_comb begin
        keep = '0;
        for (int i = 0; i < DEPTH; i++)
            keep[i] = CNT_W'(PTR_W'(PTR_W'(i) - head_nxt)) < cc_nxt;
    end

    // Store lane alignment
    always_comb begin
        case (e_funct3[head][1:0])
            2'b00:   strb_c = 4'b0001 << h_off;
            2'b01:   strb_c = 4'b0011 << h_off;
            default: strb_c = 4'b1111;
        endcase
        wdata_c = e_vk[head] << {h_off, 3'b000};
    end

    // Load data extraction
    always_comb begin
        ld_shift = mem_rdata >> {req_off, 3'b000};
        case (req_funct3)
            3'b000:  ld_ext = {{24{ld_shift[7]}}, ld_shift[7:0]};
            3'b001:  ld_ext = {{16{ld_shift[15]}}, ld_shift[15:0]};
            3'b100:  ld_ext = {24'h0, ld_shift[7:0]};
            3'b101:  ld_ext = {16'h0, ld_shift[15:0]};
            default: ld_ext = ld_shift;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= IDLE;
        else if (rdy)
            state <= state_nxt;
    end

    // Entry array: snoop, address generation, invalidation, allocation
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            e_valid   <= '0;
            e_store   <= '0;
            e_addr_ok <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                e_funct3[i] <= '0;
                e_dest[i]   <= '0;
                e_qj[i]     <= '0;
                e_qk[i]     <= '0;
                e_vj[i]     <= '0;
                e_vk[i]     <= '0;
                e_imm[i]    <= '0;
                e_addr[i]   <= '0;
            end
        end else if (rdy) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (e_valid[i] && e_qj[i] != '0) begin
                    if (e_qj[i] == cdb0_dest) begin
                        e_vj[i] <= cdb0_value;
                        e_qj[i] <= '0;
                    end else if (e_qj[i] == cdb1_dest) begin
                        e_vj[i] <= cdb1_value;
                        e_qj[i] <= '0;
                    end else if (e_qj[i] == result_dest) begin
                        e_vj[i] <= result_value;
                        e_qj[i] <= '0;
                    end
                end
                if (e_valid[i] && e_qk[i] != '0) begin
                    if (e_qk[i] == cdb0_dest) begin
                        e_vk[i] <= cdb0_value;
                        e_qk[i] <= '0;
                    end else if (e_qk[i] == cdb1_dest) begin
                        e_vk[i] <= cdb1_value;
                        e_qk[i] <= '0;
                    end else if (e_qk[i] == result_dest) begin
                        e_vk[i] <= result_value;
                        e_qk[i] <= '0;
                    end
                end
                if (e_valid[i] && e_qj[i] == '0 && !e_addr_ok[i]) begin
                    e_addr[i]    <= e_vj[i] + e_imm[i];
                    e_addr_ok[i] <= 1'b1;
                end
                if (flush && !keep[i])
                    e_valid[i] <= 1'b0;
                else if (retire && PTR_W'(i) == head)
                    e_valid[i] <= 1'b0;
                if (issue_accept && PTR_W'(i) == tail) begin
                    e_valid[i]   <= 1'b1;
                    e_store[i]   <= issue_op[3];
                    e_funct3[i]  <= issue_op[2:0];
                    e_dest[i]    <= issue_dest;
                    e_qj[i]      <= qj_cap;
                    e_vj[i]      <= vj_cap;
                    e_qk[i]      <= qk_cap;
                    e_vk[i]      <= vk_cap;
                    e_imm[i]     <= issue_imm;
                    e_addr_ok[i] <= 1'b0;
                end
            end
        end
    end

    // Pointers, counters, memory port and result registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head          <= '0;
            tail          <= '0;
            count         <= '0;
            committed_cnt <= '0;
            mem_valid     <= 1'b0;
            mem_we        <= 1'b0;
            mem_io        <= 1'b0;
            mem_addr      <= '0;
            mem_wdata     <= '0;
            mem_wstrb     <= '0;
            req_store     <= 1'b0;
            req_funct3    <= '0;
            req_dest      <= '0;
            req_off       <= '0;
            result_dest   <= '0;
            result_value  <= '0;
        end else if (rdy) begin
            head          <= head_nxt;
            tail          <= tail_nxt;
            count         <= count_nxt;
            committed_cnt <= cc_nxt;

            if (start) begin
                mem_valid  <= 1'b1;
                mem_we     <= h_store;
                mem_io     <= h_io;
                mem_addr   <= {e_addr[head][31:2], 2'b00};
                mem_wdata  <= h_store ? wdata_c : 32'h0;
                mem_wstrb  <= h_store ? strb_c : 4'h0;
                req_store  <= h_store;
                req_funct3 <= e_funct3[head];
                req_dest   <= e_dest[head];
                req_off    <= h_off;
            end else if ((state == REQ || state == DRAIN) && mem_ready) begin
                mem_valid <= 1'b0;
                mem_we    <= 1'b0;
                mem_io    <= 1'b0;
                mem_addr  <= '0;
                mem_wdata <= '0;
                mem_wstrb <= '0;
            end

            result_dest <= '0;
            if (pulse) begin
                result_dest  <= req_dest;
                result_value <= ld_ext;
            end
        end
    end

endmodule

// File: tb/tb_lsq_v2.sv
// tb_lsq_v2: directed self-checking bench for lsq_v2.
// Latency: n/a (testbench).
// Backpressure: memory responder answers only when auto_ready is set.
module tb_lsq_v2;

    localparam logic [31:0] IO_BASE = 32'h0003_0000;

    logic        clk, rst, rdy;
    logic        issue_valid;
    logic [3:0]  issue_op, issue_dest, issue_qj, issue_qk;
    logic [31:0] issue_vj, issue_vk, issue_imm;
    logic [3:0]  cdb0_dest, cdb1_dest;
    logic [31:0] cdb0_value, cdb1_value;
    logic [3:0]  rob_head_id;
    logic        commit_store, flush;
    logic [3:0]  result_dest;
    logic [31:0] result_value;
    logic        full, empty;
    logic        mem_valid, mem_we, mem_io;
    logic [31:0] mem_addr, mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_ready;
    logic [31:0] mem_rdata;

    logic        auto_ready;
    logic [31:0] rd_word;

    int checks = 0;
    int errors = 0;

    // Observed memory traffic and result pulses
    int          wr_count = 0;
    logic [31:0] wr_addr, wr_data;
    logic [3:0]  wr_strb;
    logic [31:0] ev_addr[$];
    logic [3:0]  res_q[$];
    logic [3:0]  exp_dest[$];

    lsq_v2 dut (
        .clk(clk), .rst(rst), .rdy(rdy),
        .issue_valid(issue_valid), .issue_op(issue_op), .issue_dest(issue_dest),
        .issue_qj(issue_qj), .issue_qk(issue_qk), .issue_vj(issue_vj), .issue_vk(issue_vk),
        .issue_imm(issue_imm),
        .cdb0_dest(cdb0_dest), .cdb0_value(cdb0_value),
        .cdb1_dest(cdb1_dest), .cdb1_value(cdb1_value),
        .rob_head_id(rob_head_id), .commit_store(commit_store), .flush(flush),
        .result_dest(result_dest), .result_value(result_value),
        .full(full), .empty(empty),
        .mem_valid(mem_valid), .mem_we(mem_we), .mem_io(mem_io), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
        .mem_ready(mem_ready), .mem_rdata(mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign mem_ready = mem_valid & auto_ready;
    assign mem_rdata = rd_word;

    always @(posedge clk) begin
        if (mem_valid && mem_ready) begin
            ev_addr.push_back(mem_addr);
            if (mem_we) begin
                wr_count = wr_count + 1;
                wr_addr  = mem_addr;
                wr_data  = mem_wdata;
                wr_strb  = mem_wstrb;
            end
        end
        if (result_dest != 4'd0)
            res_q.push_back(result_dest);
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic do_issue(input logic [3:0] op, input logic [3:0] dest,
                            input logic [3:0] qj, input logic [31:0] vj,
                            input logic [3:0] qk, input logic [31:0] vk,
                            input logic [31:0] imm);
        issue_valid = 1'b1;
        issue_op    = op;
        issue_dest  = dest;
        issue_qj    = qj;
        issue_vj    = vj;
        issue_qk    = qk;
        issue_vk    = vk;
        issue_imm   = imm;
        step();
        issue_valid = 1'b0;
    endtask

    task automatic commit_one();
        commit_store = 1'b1;
        step();
        commit_store = 1'b0;
    endtask

    task automatic wait_mem(input string tag);
        int n;
        n = 0;
        while (mem_valid !== 1'b1 && n < 20) begin
            step();
            n++;
        end
        chk({tag, " req"}, {31'h0, mem_valid}, 32'h1);
    endtask

    task automatic finish_load(input string tag, input logic [3:0] dest, input logic [31:0] val);
        auto_ready = 1'b1;
        step();
        auto_ready = 1'b0;
        chk({tag, " dest"}, {28'h0, result_dest}, {28'h0, dest});
        chk({tag, " value"}, result_value, val);
        step();
        chk({tag, " pulse end"}, {28'h0, result_dest}, 32'h0);
    endtask

    task automatic finish_store(input string tag);
        auto_ready = 1'b1;
        step();
        auto_ready = 1'b0;
        chk({tag, " done"}, {31'h0, mem_valid}, 32'h0);
    endtask

    initial begin
        logic seen;
        int   k, n, w0;

        rst = 1'b1; rdy = 1'b1;
        issue_valid = 0; issue_op = 0; issue_dest = 0; issue_qj = 0; issue_qk = 0;
        issue_vj = 0; issue_vk = 0; issue_imm = 0;
        cdb0_dest = 0; cdb0_value = 0; cdb1_dest = 0; cdb1_value = 0;
        rob_head_id = 0; commit_store = 0; flush = 0;
        auto_ready = 0; rd_word = 0;
        repeat (3) step();
        rst = 1'b0;
        step();

        // Reset state
        chk("rst result_dest", {28'h0, result_dest}, 32'h0);
        chk("rst result_value", result_value, 32'h0);
        chk("rst mem_valid", {31'h0, mem_valid}, 32'h0);
        chk("rst mem_addr", mem_addr, 32'h0);
        chk("rst empty", {31'h0, empty}, 32'h1);
        chk("rst full", {31'h0, full}, 32'h0);

        // SW, committed one cycle after issue
        do_issue(4'hA, 4'd1, 4'd0, 32'h100, 4'd0, 32'hAABBCCDD, 32'h4);
        commit_one();
        wait_mem("sw");
        chk("sw we", {31'h0, mem_we}, 32'h1);
        chk("sw addr", mem_addr, 32'h104);
        chk("sw strb", {28'h0, mem_wstrb}, 32'hF);
        chk("sw wdata", mem_wdata, 32'hAABBCCDD);
        finish_store("sw");
        chk("sw committed_cnt", 32'(dut.committed_cnt), 32'h0);
        chk("sw empty", {31'h0, empty}, 32'h1);

        // Sub-word loads with sign/zero extension
        rd_word = 32'h80112233;
        do_issue(4'h0, 4'd2, 4'd0, 32'h100, 4'd0, 32'h0, 32'h3);
        wait_mem("lb");
        chk("lb addr", mem_addr, 32'h100);
        chk("lb we", {31'h0, mem_we}, 32'h0);
        finish_load("lb", 4'd2, 32'hFFFFFF80);
        do_issue(4'h4, 4'd3, 4'd0, 32'h100, 4'd0, 32'h0, 32'h3);
        wait_mem("lbu");
        finish_load("lbu", 4'd3, 32'h00000080);
        rd_word = 32'h80010000;
        do_issue(4'h1, 4'd4, 4'd0, 32'h100, 4'd0, 32'h0, 32'h2);
        wait_mem("lh");
        finish_load("lh", 4'd4, 32'hFFFF8001);
        do_issue(4'h5, 4'd5, 4'd0, 32'h100, 4'd0, 32'h0, 32'h2);
        wait_mem("lhu");
        finish_load("lhu", 4'd5, 32'h00008001);

        // Base captured from cdb1 in the issue cycle; no request before addr_ok
        rd_word = 32'h12345678;
        cdb1_dest = 4'd5; cdb1_value = 32'h200;
        do_issue(4'h2, 4'd6, 4'd5, 32'hDEAD0000, 4'd0, 32'h0, 32'h10);
        cdb1_dest = 4'd0; cdb1_value = 32'h0;
        chk("cap early1", {31'h0, mem_valid}, 32'h0);
        step();
        chk("cap early2", {31'h0, mem_valid}, 32'h0);
        wait_mem("cap");
        chk("cap addr", mem_addr, 32'h210);
        finish_load("cap", 4'd6, 32'h12345678);

        // Base arriving later on cdb0
        do_issue(4'h2, 4'd7, 4'd6, 32'h0, 4'd0, 32'h0, 32'h20);
        seen = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            if (mem_valid) seen = 1'b1;
        end
        chk("snoop hold", {31'h0, seen}, 32'h0);
        cdb0_dest = 4'd6; cdb0_value = 32'h300;
        step();
        cdb0_dest = 4'd0; cdb0_value = 32'h0;
        wait_mem("snoop");
        chk("snoop addr", mem_addr, 32'h320);
        finish_load("snoop", 4'd7, 32'h12345678);

        // SB at byte offset 1
        do_issue(4'h8, 4'd10, 4'd0, 32'h40, 4'd0, 32'hA5, 32'h1);
        commit_one();
        wait_mem("sb");
        chk("sb addr", mem_addr, 32'h40);
        chk("sb strb", {28'h0, mem_wstrb}, 32'h2);
        chk("sb wdata", mem_wdata, 32'h0000A500);
        finish_store("sb");

        // SH with store data pending on tag 7
        do_issue(4'h9, 4'd8, 4'd0, 32'h50, 4'd7, 32'h0, 32'h2);
        commit_one();
        seen = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            if (mem_valid) seen = 1'b1;
        end
        chk("sh hold", {31'h0, seen}, 32'h0);
        cdb0_dest = 4'd7; cdb0_value = 32'h1234;
        step();
        cdb0_dest = 4'd0; cdb0_value = 32'h0;
        wait_mem("sh");
        chk("sh addr", mem_addr, 32'h50);
        chk("sh strb", {28'h0, mem_wstrb}, 32'hC);
        chk("sh wdata", mem_wdata, 32'h12340000);
        finish_store("sh");

        // Flush keeps the committed SB, drops uncommitted SW and LW
        do_issue(4'h8, 4'd1, 4'd0, 32'h80, 4'd0, 32'h11, 32'h0);
        commit_store = 1'b1;
        do_issue(4'hA, 4'd2, 4'd0, 32'h90, 4'd0, 32'h22, 32'h0);
        commit_store = 1'b0;
        do_issue(4'h2, 4'd3, 4'd0, 32'hA0, 4'd0, 32'h0, 32'h0);
        step();
        step();
        flush = 1'b1;
        step();
        flush = 1'b0;
        chk("flush count", 32'(dut.count), 32'h1);
        chk("flush req held", {31'h0, mem_valid}, 32'h1);
        chk("flush sb addr", mem_addr, 32'h80);
        w0 = wr_count;
        finish_store("flush sb");
        chk("flush sb data", wr_data, 32'h11);
        chk("flush sb strb", {28'h0, wr_strb}, 32'h1);
        seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            step();
            if (mem_valid) seen = 1'b1;
        end
        chk("flush no more req", {31'h0, seen}, 32'h0);
        chk("flush one write", 32'(wr_count - w0), 32'h1);
        chk("flush empty", {31'h0, empty}, 32'h1);

        // Uncommitted load in REQ at flush: drain without result
        do_issue(4'h2, 4'd4, 4'd0, 32'h100, 4'd0, 32'h0, 32'h0);
        wait_mem("drain");
        flush = 1'b1;
        step();
        flush = 1'b0;
        chk("drain held", {31'h0, mem_valid}, 32'h1);
        chk("drain empty", {31'h0, empty}, 32'h1);
        auto_ready = 1'b1;
        step();
        auto_ready = 1'b0;
        chk("drain no pulse", {28'h0, result_dest}, 32'h0);
        chk("drain released", {31'h0, mem_valid}, 32'h0);

        // IO load waits for the ROB head
        rob_head_id = 4'd3;
        rd_word = 32'hCAFEF00D;
        do_issue(4'h2, 4'd9, 4'd0, IO_BASE, 4'd0, 32'h0, 32'h8);
        seen = 1'b0;
        for (int i = 0; i < 6; i++) begin
            step();
            if (mem_valid) seen = 1'b1;
        end
        chk("io hold", {31'h0, seen}, 32'h0);
        rob_head_id = 4'd9;
        wait_mem("io");
        chk("io flag", {31'h0, mem_io}, 32'h1);
        chk("io addr", mem_addr, 32'h00030008);
        finish_load("io", 4'd9, 32'hCAFEF00D);
        rob_head_id = 4'd0;

        // Wrap: 48 mixed ops in bursts of four must retire in issue order
        ev_addr.delete();
        res_q.delete();
        exp_dest.delete();
        auto_ready = 1'b1;
        for (int b = 0; b < 12; b++) begin
            for (int j = 0; j < 4; j++) begin
                k = 4 * b + j;
                if (k % 3 == 2) begin
                    do_issue(4'hA, 4'((k % 15) + 1), 4'd0, 32'h400, 4'd0, 32'(k), 32'(4 * k));
                end else begin
                    do_issue(4'h2, 4'((k % 15) + 1), 4'd0, 32'h400, 4'd0, 32'h0, 32'(4 * k));
                    exp_dest.push_back(4'((k % 15) + 1));
                end
            end
            for (int j = 0; j < 4; j++)
                if ((4 * b + j) % 3 == 2) commit_one();
            n = 0;
            while (empty !== 1'b1 && n < 80) begin
                step();
                n++;
            end
        end
        step();
        step();
        auto_ready = 1'b0;
        chk("wrap req count", 32'(ev_addr.size()), 32'd48);
        for (int i = 0; i < 48; i++)
            if (i < ev_addr.size()) chk($sformatf("wrap addr %0d", i), ev_addr[i], 32'h400 + 32'(4 * i));
        chk("wrap result count", 32'(res_q.size()), 32'(exp_dest.size()));
        for (int i = 0; i < exp_dest.size(); i++)
            if (i < res_q.size()) chk($sformatf("wrap dest %0d", i), {28'h0, res_q[i]}, {28'h0, exp_dest[i]});

        // Fill to DEPTH-1 with blocked loads
        for (int i = 0; i < 15; i++) begin
            do_issue(4'h2, 4'(i + 1), 4'd15, 32'h0, 4'd0, 32'h0, 32'h0);
            if (i == 13) chk("fill 14 not full", {31'h0, full}, 32'h0);
        end
        chk("fill 15 full", {31'h0, full}, 32'h1);
        chk("fill count", 32'(dut.count), 32'd15);
        flush = 1'b1;
        step();
        flush = 1'b0;
        chk("fill flush empty", {31'h0, empty}, 32'h1);
        chk("fill flush full", {31'h0, full}, 32'h0);

        // Asynchronous reset while a request is outstanding
        do_issue(4'h2, 4'd2, 4'd0, 32'h100, 4'd0, 32'h0, 32'h0);
        wait_mem("arst");
        #2;
        rst = 1'b1;
        #1;
        chk("arst mem_valid", {31'h0, mem_valid}, 32'h0);
        chk("arst mem_addr", mem_addr, 32'h0);
        chk("arst result_dest", {28'h0, result_dest}, 32'h0);
        chk("arst empty", {31'h0, empty}, 32'h1);
        step();
        rst = 1'b0;
        step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
